rvv_backend_dispatch_raw_scoreboard: RTL and testbench

//  Stateful RAW checker between the dispatch stage and the vector register file.

---
 rtl/rvv_backend_dispatch_raw_scoreboard_pkg.sv | 31 +++
 rtl/rvv_backend_dispatch_raw_cnt.sv | 55 +++++
 rtl/rvv_backend_dispatch_raw_scoreboard.sv | 112 +++++++++++
 tb/tb_rvv_backend_dispatch_raw_scoreboard.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_backend_dispatch_raw_scoreboard_pkg.sv
// Shared types and default sizes for the dispatch RAW scoreboard.
// The check record carries operand indices and valids; the wait record carries the per-operand stall reasons.
package rvv_backend_dispatch_raw_scoreboard_pkg;

  localparam int RAW_DISPATCH_NUM = 2;
  localparam int RAW_RETIRE_NUM   = 4;
  localparam int RAW_VREG_NUM     = 32;
  localparam int RAW_VREG_IDX_W   = $clog2(RAW_VREG_NUM);
  localparam int RAW_CNT_W        = 3;
  localparam int V0_INDEX         = 0;

  typedef struct packed {
    logic [RAW_VREG_IDX_W-1:0] vs1;
    logic [RAW_VREG_IDX_W-1:0] vs2;
    logic [RAW_VREG_IDX_W-1:0] vd;
    logic                      vs1_valid;
    logic                      vs2_valid;
    logic                      vs3_valid;
    logic                      vm;
    logic                      w_valid;
  } RAW_CHK_t;

  typedef struct packed {
    logic vs1_wait;
    logic vs2_wait;
    logic vd_wait;
    logic v0_wait;
    logic full_wait;
  } RAW_WAIT_t;

endpackage

// File: rtl/rvv_backend_dispatch_raw_cnt.sv
// One in-flight write counter: popcount inc/dec, clamps to 0 on underflow, cleared by flush/rst.
// With RVV_RAW_WB_BYPASS_EN defined, pend already discounts same-cycle writebacks.
module rvv_backend_dispatch_raw_cnt
  import rvv_backend_dispatch_raw_scoreboard_pkg::*;
#(
  parameter int CNT_W = RAW_CNT_W,
  parameter int INC_N = RAW_DISPATCH_NUM,
  parameter int DEC_N = RAW_RETIRE_NUM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [INC_N-1:0] inc,
  input  logic [DEC_N-1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic             pend,
  output logic             underflow
);

  localparam int SUM_W = CNT_W + $clog2(INC_N + DEC_N + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] inc_sum, dec_sum, avail;

  always_comb begin
    inc_sum   = '0;
    dec_sum   = '0;
    for (int i = 0; i < INC_N; i++) inc_sum = inc_sum + SUM_W'(inc[i]);
    for (int p = 0; p < DEC_N; p++) dec_sum = dec_sum + SUM_W'(dec[p]);
    avail     = SUM_W'(cnt_q) + inc_sum;
    underflow = 1'b0;
    if (flush) begin
      cnt_d = '0;
    end else if (dec_sum > avail) begin
      cnt_d     = '0;
      underflow = 1'b1;
    end else begin
      cnt_d = CNT_W'(avail - dec_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

`ifdef RVV_RAW_WB_BYPASS_EN
  assign pend = SUM_W'(cnt_q) > dec_sum;
`else
  assign pend = |cnt_q;
`endif

  assign cnt = cnt_q;

endmodule

// File: rtl/rvv_backend_dispatch_raw_scoreboard.sv
// RAW checker between dispatch and the VRF: per-vreg in-flight write counters, in-order fire chain.
// fire/wait_o are combinational; writeback bypass into pend is selected by RVV_RAW_WB_BYPASS_EN.
module rvv_backend_dispatch_raw_scoreboard
  import rvv_backend_dispatch_raw_scoreboard_pkg::*;
#(
  parameter int DISPATCH_NUM = RAW_DISPATCH_NUM,
  parameter int RETIRE_NUM   = RAW_RETIRE_NUM,
  parameter int VREG_NUM     = RAW_VREG_NUM,
  parameter int CNT_W        = RAW_CNT_W
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic      [DISPATCH_NUM-1:0]                chk_valid,
  input  RAW_CHK_t  [DISPATCH_NUM-1:0]                chk_uop,
  output logic      [DISPATCH_NUM-1:0]                fire,
  output RAW_WAIT_t [DISPATCH_NUM-1:0]                wait_o,
  input  logic      [RETIRE_NUM-1:0]                  wb_valid,
  input  logic      [RETIRE_NUM-1:0][RAW_VREG_IDX_W-1:0] wb_index,
  output logic                                        busy,
  output logic                                        err_underflow
);

  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]        cnt [VREG_NUM];
  logic [VREG_NUM-1:0]     pend, nz, uf;
  logic [DISPATCH_NUM-1:0] inc_mat [VREG_NUM];
  logic [RETIRE_NUM-1:0]   dec_mat [VREG_NUM];
  logic                    err_underflow_q, err_underflow_d;

  RAW_CHK_t       u;
  logic           hit_vs1, hit_vs2, hit_vd, hit_v0, chain;
  logic [CNT_W:0] full_acc;

  // Older slots are resolved first, so a younger slot sees their final fire bits.
  always_comb begin
    fire     = '0;
    wait_o   = '0;
    chain    = ~flush;
    u        = '0;
    hit_vs1  = 1'b0;
    hit_vs2  = 1'b0;
    hit_vd   = 1'b0;
    hit_v0   = 1'b0;
    full_acc = '0;
    for (int i = 0; i < DISPATCH_NUM; i++) begin
      u        = chk_uop[i];
      hit_vs1  = 1'b0;
      hit_vs2  = 1'b0;
      hit_vd   = 1'b0;
      hit_v0   = 1'b0;
      full_acc = {1'b0, cnt[u.vd]};
      for (int j = 0; j < i; j++) begin
        if (chk_valid[j] && chk_uop[j].w_valid) begin
          hit_vs1 = hit_vs1 | (chk_uop[j].vd == u.vs1);
          hit_vs2 = hit_vs2 | (chk_uop[j].vd == u.vs2);
          hit_vd  = hit_vd  | (chk_uop[j].vd == u.vd);
          hit_v0  = hit_v0  | (chk_uop[j].vd == RAW_VREG_IDX_W'(V0_INDEX));
          if (fire[j] && (chk_uop[j].vd == u.vd)) full_acc = full_acc + (CNT_W+1)'(1);
        end
      end
      if (chk_valid[i]) begin
        wait_o[i].vs1_wait  = u.vs1_valid & (pend[u.vs1] | hit_vs1);
        wait_o[i].vs2_wait  = u.vs2_valid & (pend[u.vs2] | hit_vs2);
        wait_o[i].vd_wait   = u.vs3_valid & (pend[u.vd]  | hit_vd);
        wait_o[i].v0_wait   = ~u.vm       & (pend[V0_INDEX] | hit_v0);
        wait_o[i].full_wait = u.w_valid   & (full_acc >= CNT_MAX);
      end
      fire[i] = chk_valid[i] & ~(|wait_o[i]) & chain;
      chain   = fire[i];
    end
  end

  always_comb begin
    for (int r = 0; r < VREG_NUM; r++) begin
      for (int i = 0; i < DISPATCH_NUM; i++)
        inc_mat[r][i] = fire[i] & chk_uop[i].w_valid & (chk_uop[i].vd == RAW_VREG_IDX_W'(r));
      for (int p = 0; p < RETIRE_NUM; p++)
        dec_mat[r][p] = wb_valid[p] & (wb_index[p] == RAW_VREG_IDX_W'(r));
    end
  end

  for (genvar r = 0; r < VREG_NUM; r++) begin : g_cnt
    rvv_backend_dispatch_raw_cnt #(
      .CNT_W (CNT_W),
      .INC_N (DISPATCH_NUM),
      .DEC_N (RETIRE_NUM)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .inc       (inc_mat[r]),
      .dec       (dec_mat[r]),
      .cnt       (cnt[r]),
      .pend      (pend[r]),
      .underflow (uf[r])
    );
    assign nz[r] = |cnt[r];
  end

  always_comb err_underflow_d = err_underflow_q | (|uf);

  always_ff @(posedge clk) begin
    if (rst) err_underflow_q <= 1'b0;
    else     err_underflow_q <= err_underflow_d;
  end

  assign busy          = |nz;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_rvv_backend_dispatch_raw_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_rvv_backend_dispatch_raw_scoreboard;
  import rvv_backend_dispatch_raw_scoreboard_pkg::*;

  localparam int DN = RAW_DISPATCH_NUM;
  localparam int RN = RAW_RETIRE_NUM;

  logic                                clk = 1'b0;
  logic                                rst, flush;
  logic      [DN-1:0]                  chk_valid;
  RAW_CHK_t  [DN-1:0]                  chk_uop;
  logic      [DN-1:0]                  fire;
  RAW_WAIT_t [DN-1:0]                  wait_o;
  logic      [RN-1:0]                  wb_valid;
  logic      [RN-1:0][RAW_VREG_IDX_W-1:0] wb_index;
  logic                                busy, err_underflow;

  rvv_backend_dispatch_raw_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .chk_valid     (chk_valid),
    .chk_uop       (chk_uop),
    .fire          (fire),
    .wait_o        (wait_o),
    .wb_valid      (wb_valid),
    .wb_index      (wb_index),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        step;
    logic [1:0] fire;
    RAW_WAIT_t w0;
    RAW_WAIT_t w1;
    logic      busy;
    logic      err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  task automatic chk(input int step, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL step%0d %s: got %0h expected %0h", step, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      chk(e_m.step, "fire",  32'(fire),          32'(e_m.fire));
      chk(e_m.step, "wait0", 32'(wait_o[0]),     32'(e_m.w0));
      chk(e_m.step, "wait1", 32'(wait_o[1]),     32'(e_m.w1));
      chk(e_m.step, "busy",  32'(busy),          32'(e_m.busy));
      chk(e_m.step, "err",   32'(err_underflow), 32'(e_m.err));
    end
  end

  function automatic RAW_CHK_t uop(input int vs1, input int vs2, input int vd,
                                   input logic r1, input logic r2, input logic r3,
                                   input logic vm, input logic wv);
    RAW_CHK_t t;
    t.vs1 = RAW_VREG_IDX_W'(vs1);
    t.vs2 = RAW_VREG_IDX_W'(vs2);
    t.vd  = RAW_VREG_IDX_W'(vd);
    t.vs1_valid = r1;
    t.vs2_valid = r2;
    t.vs3_valid = r3;
    t.vm = vm;
    t.w_valid = wv;
    return t;
  endfunction

  function automatic RAW_WAIT_t wt(input logic a, input logic b, input logic c, input logic d, input logic f);
    RAW_WAIT_t t;
    t.vs1_wait = a;
    t.vs2_wait = b;
    t.vd_wait = c;
    t.v0_wait = d;
    t.full_wait = f;
    return t;
  endfunction

  task automatic idle();
    chk_valid = '0;
    chk_uop   = '0;
    flush     = 1'b0;
    wb_valid  = '0;
    wb_index  = '0;
  endtask

  task automatic expect_step(input logic [1:0] f, input RAW_WAIT_t a, input RAW_WAIT_t b,
                             input logic bz, input logic er);
    exp_t e;
    e.step = step_no;
    e.fire = f;
    e.w0 = a;
    e.w1 = b;
    e.busy = bz;
    e.err = er;
    exp_q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  RAW_WAIT_t W0, WFULL, WV0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    W0    = wt(0, 0, 0, 0, 0);
    WFULL = wt(0, 0, 0, 0, 1);
    WV0   = wt(0, 0, 0, 1, 0);
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // S0 reset state
    expect_step(2'b00, W0, W0, 1'b0, 1'b0);
    // S1 slot0 writes v4, slot1 reads vs2=v4
    chk_valid = 2'b11;
    chk_uop[0] = uop(0, 0, 4, 0, 0, 0, 1, 1);
    chk_uop[1] = uop(0, 4, 0, 0, 1, 0, 1, 0);
    expect_step(2'b01, W0, wt(0, 1, 0, 0, 0), 1'b0, 1'b0);
    // S2 intra-group vs3 hazard on v6
    chk_uop[0] = uop(0, 0, 6, 0, 0, 0, 1, 1);
    chk_uop[1] = uop(0, 0, 6, 0, 0, 1, 1, 0);
    expect_step(2'b01, W0, wt(0, 0, 1, 0, 0), 1'b1, 1'b0);
    // S3 read v4 while it writes back (v6 also drained)
    idle();
    chk_valid = 2'b01;
    chk_uop[0] = uop(4, 0, 0, 1, 0, 0, 1, 0);
    wb_valid = 4'b0011;
    wb_index[0] = 5'd4;
    wb_index[1] = 5'd6;
`ifdef RVV_RAW_WB_BYPASS_EN
    expect_step(2'b01, W0, W0, 1'b1, 1'b0);
`else
    expect_step(2'b00, wt(1, 0, 0, 0, 0), W0, 1'b1, 1'b0);
`endif
    // S4 same read, no writeback
    wb_valid = '0;
    expect_step(2'b01, W0, W0, 1'b0, 1'b0);
    // S5 both slots write v0 -> cnt[0]=2
    chk_valid = 2'b11;
    chk_uop[0] = uop(0, 0, 0, 0, 0, 0, 1, 1);
    chk_uop[1] = uop(0, 0, 0, 0, 0, 0, 1, 1);
    expect_step(2'b11, W0, W0, 1'b0, 1'b0);
    // S6 masked uop stalls, clean younger slot blocked
    chk_uop[0] = uop(0, 0, 0, 0, 0, 0, 0, 0);
    chk_uop[1] = uop(0, 0, 0, 0, 0, 0, 1, 0);
    expect_step(2'b00, WV0, W0, 1'b1, 1'b0);
    // S7 two ports drain v0
    idle();
    wb_valid = 4'b0011;
    expect_step(2'b00, W0, W0, 1'b1, 1'b0);
    // S8 intra-group v0 hazard
    idle();
    chk_valid = 2'b11;
    chk_uop[0] = uop(0, 0, 0, 0, 0, 0, 1, 1);
    chk_uop[1] = uop(0, 0, 0, 0, 0, 0, 0, 0);
    expect_step(2'b01, W0, WV0, 1'b0, 1'b0);
    // S9..S11 fill v7 to 6, v0 drained in S9
    chk_uop[0] = uop(0, 0, 7, 0, 0, 0, 1, 1);
    chk_uop[1] = uop(0, 0, 7, 0, 0, 0, 1, 1);
    wb_valid = 4'b0001;
    wb_index[0] = 5'd0;
    expect_step(2'b11, W0, W0, 1'b1, 1'b0);
    wb_valid = '0;
    expect_step(2'b11, W0, W0, 1'b1, 1'b0);
    expect_step(2'b11, W0, W0, 1'b1, 1'b0);
    // S12 cnt[7]=6: second writer hits the ceiling
    expect_step(2'b01, W0, WFULL, 1'b1, 1'b0);
    // S13 cnt[7]=7: any writer blocked
    chk_valid = 2'b01;
    expect_step(2'b00, WFULL, W0, 1'b1, 1'b0);
    // S14/S15 exact drain 7 -> 3 -> 0
    idle();
    wb_valid = 4'b1111;
    for (int p = 0; p < RN; p++) wb_index[p] = 5'd7;
    expect_step(2'b00, W0, W0, 1'b1, 1'b0);
    wb_valid = 4'b0111;
    expect_step(2'b00, W0, W0, 1'b1, 1'b0);
    // S16 drained without error
    idle();
    expect_step(2'b00, W0, W0, 1'b0, 1'b0);
    // S17 slot0 writes v3
    chk_valid = 2'b01;
    chk_uop[0] = uop(0, 0, 3, 0, 0, 0, 1, 1);
    expect_step(2'b01, W0, W0, 1'b0, 1'b0);
    // S18 two writebacks to v3 with cnt=1
    idle();
    wb_valid = 4'b0011;
    wb_index[0] = 5'd3;
    wb_index[1] = 5'd3;
    expect_step(2'b00, W0, W0, 1'b1, 1'b0);
    // S19 clamped to zero, error sticky
    idle();
    expect_step(2'b00, W0, W0, 1'b0, 1'b1);
    // S20 v3 readable again, error still held
    chk_valid = 2'b01;
    chk_uop[0] = uop(3, 0, 0, 1, 0, 0, 1, 0);
    expect_step(2'b01, W0, W0, 1'b0, 1'b1);
    // S21 pend v1 and v9
    chk_valid = 2'b11;
    chk_uop[0] = uop(0, 0, 1, 0, 0, 0, 1, 1);
    chk_uop[1] = uop(0, 0, 9, 0, 0, 0, 1, 1);
    expect_step(2'b11, W0, W0, 1'b0, 1'b1);
    // S22 flush with a fireable slot and a wb
    idle();
    flush = 1'b1;
    chk_valid = 2'b01;
    chk_uop[0] = uop(0, 0, 5, 0, 0, 0, 1, 1);
    wb_valid = 4'b0001;
    wb_index[0] = 5'd1;
    expect_step(2'b00, W0, W0, 1'b1, 1'b1);
    // S23 all cleared, error held
    idle();
    expect_step(2'b00, W0, W0, 1'b0, 1'b1);
    // S24 v1/v9 readable
    chk_valid = 2'b11;
    chk_uop[0] = uop(0, 1, 0, 0, 1, 0, 1, 0);
    chk_uop[1] = uop(0, 0, 9, 0, 0, 1, 1, 0);
    expect_step(2'b11, W0, W0, 1'b0, 1'b1);
    // S25 leave v2 pending, then reset mid-operation
    idle();
    chk_valid = 2'b01;
    chk_uop[0] = uop(0, 0, 2, 0, 0, 0, 1, 1);
    expect_step(2'b01, W0, W0, 1'b0, 1'b1);
    idle();
    rst = 1'b1;
    wb_valid = 4'b0001;
    wb_index[0] = 5'd20;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    // S26 pending state and error dropped
    expect_step(2'b00, W0, W0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
